// File: rtl/sd4_mac_pkg.sv
// Shared constants, FSM state type and shift helper for the SD4 MAC datapath.
package sd4_mac_pkg;

  localparam int unsigned PP_W    = 5;
  localparam int unsigned EXP_W   = 5;
  localparam int unsigned N_TERMS = 9;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } acc_state_e;

  // Clamp a shift distance so an arithmetic shift never exceeds lim.
  function automatic int unsigned clamp_shift(input int unsigned d, input int unsigned lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/sd4_term_aligner.sv
// Aligns nine signed partial products to the beat's maximum exponent and sums them.
module sd4_term_aligner
  import sd4_mac_pkg::*;
#(
  parameter int unsigned FRAC_W = 4
) (
  input  logic        [N_TERMS*PP_W-1:0]  signed_pp_in,
  input  logic        [N_TERMS*EXP_W-1:0] exp_in,
  input  logic        [EXP_W-1:0]         exp_max_in,
  output logic signed [FRAC_W+8:0]        beat_sum
);

  localparam int unsigned TermW = FRAC_W + 5;
  localparam int unsigned SumW  = FRAC_W + 9;

  logic [N_TERMS-1:0][TermW-1:0] terms;

  for (genvar i = 0; i < N_TERMS; i++) begin : g_term
    logic signed [PP_W-1:0]  pp;
    logic        [EXP_W-1:0] e;
    logic        [EXP_W-1:0] d;
    logic signed [TermW-1:0] t;

    assign pp = signed_pp_in[(N_TERMS-1-i)*PP_W +: PP_W];
    assign e  = exp_in[(N_TERMS-1-i)*EXP_W +: EXP_W];
    // Terms claiming an exponent above the beat max are treated as already aligned.
    assign d  = (e > exp_max_in) ? '0 : exp_max_in - e;
    assign t  = (TermW'(pp) <<< FRAC_W) >>> clamp_shift(32'(d), FRAC_W + 4);
    assign terms[i] = t;
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      beat_sum = beat_sum + SumW'($signed(terms[i]));
    end
  end

endmodule

// File: rtl/sd4_align_accumulator.sv
// Block-floating-point accumulator over ACC_LEN aligned beats with valid/ready output.
// Optional SD4_ACC_SAT_EN: saturating adds plus a sticky per-group overflow flag on out_ovf.
module sd4_align_accumulator
  import sd4_mac_pkg::*;
#(
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned FRAC_W  = 4,
  parameter int unsigned ACC_W   = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic        [N_TERMS*PP_W-1:0]  signed_pp_in,
  input  logic        [N_TERMS*EXP_W-1:0] exp_in,
  input  logic        [EXP_W-1:0]    exp_max_in,
  input  logic        [EXP_W-1:0]    exp_bias_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_data,
  output logic        [EXP_W-1:0]    out_exp,
  output logic        [EXP_W-1:0]    out_bias,
  output logic                       out_ovf
);

  localparam int unsigned SumW = FRAC_W + 9;
  localparam int unsigned CntW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ACC_LEN - 1);

  logic signed [SumW-1:0]  beat_sum;
  logic signed [ACC_W-1:0] beat_ext;

  acc_state_e              state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0]        acc_exp_q, acc_exp_d;
  logic [EXP_W-1:0]        bias_q, bias_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic [EXP_W-1:0]        out_exp_q, out_exp_d;
  logic [EXP_W-1:0]        out_bias_q, out_bias_d;

  logic                    accept, rebase, complete;
  int unsigned             shift;
  logic signed [ACC_W-1:0] op_a, op_b, acc_sum;

  sd4_term_aligner #(
    .FRAC_W(FRAC_W)
  ) u_aligner (
    .signed_pp_in(signed_pp_in),
    .exp_in      (exp_in),
    .exp_max_in  (exp_max_in),
    .beat_sum    (beat_sum)
  );

  assign beat_ext = ACC_W'(beat_sum);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign rebase   = exp_max_in > acc_exp_q;

  // Whichever operand has the smaller exponent is shifted down before the add.
  always_comb begin
    shift = 0;
    op_a  = acc_q;
    op_b  = beat_ext;
    if (rebase) begin
      shift = clamp_shift(32'(exp_max_in - acc_exp_q), ACC_W - 1);
      op_a  = acc_q >>> shift;
    end else begin
      shift = clamp_shift(32'(acc_exp_q - exp_max_in), ACC_W - 1);
      op_b  = beat_ext >>> shift;
    end
  end

`ifdef SD4_ACC_SAT_EN
  logic                    ovf_q, ovf_d, out_ovf_q, out_ovf_d, add_ovf;
  logic [ACC_W:0]          sum_wide;
  logic signed [ACC_W-1:0] shift_src, shift_res;

  always_comb begin
    sum_wide  = {op_a[ACC_W-1], op_a} + {op_b[ACC_W-1], op_b};
    acc_sum   = sum_wide[ACC_W-1:0];
    shift_src = rebase ? acc_q : beat_ext;
    shift_res = rebase ? op_a : op_b;
    // Loss: a value carrying information collapses entirely into sign fill.
    add_ovf   = (shift_src != {ACC_W{shift_src[ACC_W-1]}}) &&
                (shift_res == {ACC_W{shift_src[ACC_W-1]}});
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      add_ovf = 1'b1;
    end
  end

  assign out_ovf = out_ovf_q;
`else
  assign acc_sum = op_a + op_b;
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_exp_d   = acc_exp_q;
    bias_d      = bias_q;
    complete    = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_exp_d   = out_exp_q;
    out_bias_d  = out_bias_q;
`ifdef SD4_ACC_SAT_EN
    ovf_d       = ovf_q;
    out_ovf_d   = out_ovf_q;
`endif
    if (accept) begin
      if (state_q == StIdle) begin
        acc_d     = beat_ext;
        acc_exp_d = exp_max_in;
        bias_d    = exp_bias_in;
`ifdef SD4_ACC_SAT_EN
        ovf_d     = 1'b0;
`endif
        if (ACC_LEN == 1) begin
          complete = 1'b1;
        end else begin
          cnt_d   = CntW'(1);
          state_d = StAccum;
        end
      end else begin
        acc_d     = acc_sum;
        acc_exp_d = rebase ? exp_max_in : acc_exp_q;
`ifdef SD4_ACC_SAT_EN
        ovf_d     = ovf_q || add_ovf;
`endif
        if (cnt_q == LastCnt) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_d;
      out_exp_d   = acc_exp_d;
      out_bias_d  = bias_d;
`ifdef SD4_ACC_SAT_EN
      out_ovf_d   = ovf_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      acc_exp_q   <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_exp_q   <= '0;
      out_bias_q  <= '0;
`ifdef SD4_ACC_SAT_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_exp_q   <= acc_exp_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_exp_q   <= out_exp_d;
      out_bias_q  <= out_bias_d;
`ifdef SD4_ACC_SAT_EN
      ovf_q       <= ovf_d;
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_exp   = out_exp_q;
  assign out_bias  = out_bias_q;

endmodule

// File: tb/tb_sd4_align_accumulator.sv
// Four accumulator configurations share one stimulus stream and are checked against an
// arithmetic model every cycle, plus hand-computed expectations for the directed cases.
module tb_sd4_align_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [44:0] signed_pp_in, exp_in;
  logic [4:0]  exp_max_in, exp_bias_in;

  logic [3:0]         dv, dr, dovf;
  logic [4:0]         de [4];
  logic [4:0]         db [4];
  logic signed [19:0] od0, od1, od2;
  logic signed [13:0] od3;
  longint             dd [4];

  always_comb begin
    dd[0] = longint'(od0);
    dd[1] = longint'(od1);
    dd[2] = longint'(od2);
    dd[3] = longint'(od3);
  end

  sd4_align_accumulator #(.ACC_LEN(4), .FRAC_W(4), .ACC_W(20)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dr[0]), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(dv[0]),
    .out_ready(out_ready), .out_data(od0), .out_exp(de[0]), .out_bias(db[0]), .out_ovf(dovf[0])
  );
  sd4_align_accumulator #(.ACC_LEN(2), .FRAC_W(4), .ACC_W(20)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dr[1]), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(dv[1]),
    .out_ready(out_ready), .out_data(od1), .out_exp(de[1]), .out_bias(db[1]), .out_ovf(dovf[1])
  );
  sd4_align_accumulator #(.ACC_LEN(1), .FRAC_W(4), .ACC_W(20)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dr[2]), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(dv[2]),
    .out_ready(out_ready), .out_data(od2), .out_exp(de[2]), .out_bias(db[2]), .out_ovf(dovf[2])
  );
  sd4_align_accumulator #(.ACC_LEN(4), .FRAC_W(4), .ACC_W(14)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dr[3]), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(dv[3]),
    .out_ready(out_ready), .out_data(od3), .out_exp(de[3]), .out_bias(db[3]), .out_ovf(dovf[3])
  );

  int n_tot = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  int pp_v [9];
  int e_v  [9];

  int LEN [4] = '{4, 2, 1, 4};
  int WID [4] = '{20, 20, 20, 14};

  int     m_cnt  [4];
  longint m_acc  [4];
  int     m_exp  [4];
  int     m_bias [4];
  bit     m_ov   [4];
  longint m_od   [4];
  int     m_oe   [4];
  int     m_ob   [4];

  task automatic check(input string name, input int k, input longint act, input longint exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d got=%0d expected=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic longint fit(input longint x, input int w);
    longint half = longint'(1) << (w - 1);
`ifdef SD4_ACC_SAT_EN
    if (x > half - 1) return half - 1;
    if (x < -half) return -half;
    return x;
`else
    longint m = half * 2;
    longint y = x & (m - 1);
    if (y >= half) y -= m;
    return y;
`endif
  endfunction

  // Sum of the nine terms scaled by 16 and divided (flooring) by 2^distance-to-max.
  function automatic longint beat_model();
    longint s = 0;
    for (int i = 0; i < 9; i++) begin
      logic [4:0] raw;
      int v, e, d;
      raw = signed_pp_in[(8-i)*5 +: 5];
      v = (raw >= 16) ? int'(raw) - 32 : int'(raw);
      e = int'(exp_in[(8-i)*5 +: 5]);
      d = (e > int'(exp_max_in)) ? 0 : int'(exp_max_in) - e;
      s += (longint'(v) * 16) >>> imin(d, 8);
    end
    return s;
  endfunction

  task automatic model_step();
    longint bs = beat_model();
    int mx = int'(exp_max_in);
    for (int k = 0; k < 4; k++) begin
      bit rdy, comp;
      rdy  = !m_ov[k] || out_ready;
      comp = 1'b0;
      if (rst) begin
        m_cnt[k] = 0; m_acc[k] = 0; m_exp[k] = 0; m_bias[k] = 0;
        m_ov[k] = 1'b0; m_od[k] = 0; m_oe[k] = 0; m_ob[k] = 0;
      end else begin
        if (in_valid && rdy) begin
          if (m_cnt[k] == 0) begin
            m_acc[k] = bs; m_exp[k] = mx; m_bias[k] = int'(exp_bias_in);
          end else if (mx > m_exp[k]) begin
            m_acc[k] = fit((m_acc[k] >>> imin(mx - m_exp[k], WID[k] - 1)) + bs, WID[k]);
            m_exp[k] = mx;
          end else begin
            m_acc[k] = fit(m_acc[k] + (bs >>> imin(m_exp[k] - mx, WID[k] - 1)), WID[k]);
          end
          m_cnt[k]++;
          if (m_cnt[k] == LEN[k]) begin
            comp = 1'b1;
            m_cnt[k] = 0;
          end
        end
        if (comp) begin
          m_ov[k] = 1'b1; m_od[k] = m_acc[k]; m_oe[k] = m_exp[k]; m_ob[k] = m_bias[k];
        end else if (out_ready) begin
          m_ov[k] = 1'b0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        check("in_ready", k, longint'(dr[k]), longint'(!m_ov[k] || out_ready));
        check("out_valid", k, longint'(dv[k]), longint'(m_ov[k]));
        if (m_ov[k]) begin
          check("out_data", k, dd[k], m_od[k]);
          check("out_exp", k, longint'(de[k]), longint'(m_oe[k]));
          check("out_bias", k, longint'(db[k]), longint'(m_ob[k]));
        end
`ifndef SD4_ACC_SAT_EN
        check("out_ovf", k, longint'(dovf[k]), 0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic fill(input int p, input int e);
    for (int i = 0; i < 9; i++) begin
      pp_v[i] = p;
      e_v[i]  = e;
    end
  endtask

  task automatic drive(input int mx, input int bias);
    for (int i = 0; i < 9; i++) begin
      signed_pp_in[(8-i)*5 +: 5] = pp_v[i][4:0];
      exp_in[(8-i)*5 +: 5]       = e_v[i][4:0];
    end
    exp_max_in  = mx[4:0];
    exp_bias_in = bias[4:0];
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fill(0, 0);
    drive(0, 0);
    tick();
    tick();
    chk_on = 1'b1;
    check("rst_valid", 0, longint'(dv[0]), 0);
    check("rst_data", 0, dd[0], 0);
    check("rst_exp", 0, longint'(de[0]), 0);
    check("rst_bias", 0, longint'(db[0]), 0);
    check("rst_ready", 0, longint'(dr[0]), 1);
    rst = 1'b0;

    // Two equal-exponent beats: 2 * 9 * 16.
    fill(1, 3); drive(3, 7); in_valid = 1'b1;
    tick();
    check("t1_early", 1, longint'(dv[1]), 0);
    tick();
    in_valid = 1'b0;
    check("t1_valid", 1, longint'(dv[1]), 1);
    check("t1_data", 1, dd[1], 288);
    check("t1_exp", 1, longint'(de[1]), 3);
    check("t1_bias", 1, longint'(db[1]), 7);
    tick();

    // Single beat: -32 + (16 >>> 4).
    pulse_reset();
    fill(0, 0); pp_v[0] = -2; e_v[0] = 5; pp_v[1] = 1; e_v[1] = 1;
    drive(5, 2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sb_data", 2, dd[2], -31);
    check("sb_exp", 2, longint'(de[2]), 5);

    // Rebase: 144 >>> 2 + 144.
    pulse_reset();
    fill(1, 3); drive(3, 1); in_valid = 1'b1;
    tick();
    fill(1, 5); drive(5, 1);
    tick();
    in_valid = 1'b0;
    check("rb_data", 1, dd[1], 180);
    check("rb_exp", 1, longint'(de[1]), 5);

    // Four beats of 2160 into 14 bits and 20 bits.
    pulse_reset();
    fill(15, 0); drive(0, 4); in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
`ifdef SD4_ACC_SAT_EN
    check("w14_data", 3, dd[3], 8191);
    check("w14_ovf", 3, longint'(dovf[3]), 1);
`else
    check("w14_data", 3, dd[3], -7744);
    check("w14_ovf", 3, longint'(dovf[3]), 0);
`endif
    check("w20_data", 0, dd[0], 8640);

    // Backpressure with the next beat waiting.
    out_ready = 1'b0;
    fill(1, 0); drive(0, 0); in_valid = 1'b1;
    repeat (5) begin
      tick();
      check("bp_ready", 0, longint'(dr[0]), 0);
      check("bp_valid", 0, longint'(dv[0]), 1);
      check("bp_data", 0, dd[0], 8640);
    end
    out_ready = 1'b1;
    tick();
    check("bp_clear", 0, longint'(dv[0]), 0);
    repeat (3) tick();
    in_valid = 1'b0;
    check("bp_next", 0, dd[0], 576);
    check("bp_next_v", 0, longint'(dv[0]), 1);
    tick();
    check("bp_nodup", 0, longint'(dv[0]), 0);

    // Reset after one of four beats discards that beat.
    pulse_reset();
    fill(2, 0); drive(0, 0); in_valid = 1'b1;
    tick();
    pulse_reset();
    check("mr_valid", 0, longint'(dv[0]), 0);
    check("mr_data", 0, dd[0], 0);
    check("mr_exp", 0, longint'(de[0]), 0);
    check("mr_bias", 0, longint'(db[0]), 0);
    fill(1, 0); drive(0, 5); in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    check("mr_sum", 0, dd[0], 576);
    check("mr_bias5", 0, longint'(db[0]), 5);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      int mx;
      mx = 0;
      for (int i = 0; i < 9; i++) begin
        pp_v[i] = int'($urandom_range(0, 31)) - 16;
        e_v[i]  = int'($urandom_range(0, 31));
        if (e_v[i] > mx) mx = e_v[i];
      end
      if ($urandom_range(0, 3) == 0) mx = int'($urandom_range(0, 31));
      drive(mx, int'($urandom_range(0, 31)));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
